// File: rtl/dmem_if.sv
// CPU data-port bus between the load/store unit and the data-memory responder.
interface dmem_if;
    logic [31:0] memAddr;
    logic        memWr;
    logic [3:0]  wrMask;
    logic [31:0] memWriteData;
    logic [31:0] memReadData;
    logic        timerIrq;
    logic        accessFault;

    modport master (
        output memAddr, memWr, wrMask, memWriteData,
        input  memReadData, timerIrq, accessFault
    );

    modport slave (
        input  memAddr, memWr, wrMask, memWriteData,
        output memReadData, timerIrq, accessFault
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: on-chip RAM, a 64-bit timer MMIO window, and fault
// flagging for unmapped addresses. Reads are combinational, writes commit on the edge.
module dmem_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000
) (
    input  logic   clk,
    input  logic   reset,
    dmem_if.slave  bus
);
    localparam int unsigned RAM_AW = $clog2(RAM_WORDS);
    localparam int unsigned BYTE_AW = RAM_AW + 2;

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_STATUS   = 3'd5;

    logic [31:0]       ram [RAM_WORDS];
    logic [63:0]       mtime;
    logic [63:0]       mtimecmp;
    logic              en;
    logic              ie;
    logic              pend;
    logic              fault;

    logic              in_ram;
    logic              in_mmio;
    logic              unmapped;
    logic              rd_en;
    logic [RAM_AW-1:0] ram_idx;
    logic [2:0]        off;
    logic              mmio_wr;
    logic              any_lane;
    logic              time_wr;
    logic              clr_write;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? data[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    // Region decode; RAM wins if a mis-parameterised window ever overlaps it.
    always_comb begin
        in_ram    = (bus.memAddr >> BYTE_AW) == 32'd0;
        in_mmio   = !in_ram && (bus.memAddr[31:5] == MMIO_BASE[31:5]);
        unmapped  = !in_ram && !in_mmio;
        rd_en     = 1'b1;
        ram_idx   = bus.memAddr[BYTE_AW-1:2];
        off       = bus.memAddr[4:2];
        mmio_wr   = bus.memWr && in_mmio;
        any_lane  = |bus.wrMask;
        time_wr   = mmio_wr && any_lane && (off == OFF_MTIME_LO || off == OFF_MTIME_HI);
        clr_write = mmio_wr && (off == OFF_STATUS) && bus.wrMask[0] && bus.memWriteData[0];
    end

    // Combinational read path.
    always_comb begin
        bus.memReadData = 32'd0;
        if (in_ram) begin
            bus.memReadData = ram[ram_idx];
        end else if (in_mmio) begin
            case (off)
                OFF_MTIME_LO: bus.memReadData = mtime[31:0];
                OFF_MTIME_HI: bus.memReadData = mtime[63:32];
                OFF_CMP_LO:   bus.memReadData = mtimecmp[31:0];
                OFF_CMP_HI:   bus.memReadData = mtimecmp[63:32];
                OFF_CTRL:     bus.memReadData = {30'd0, ie, en};
                OFF_STATUS:   bus.memReadData = {31'd0, pend};
                default:      bus.memReadData = 32'd0;
            endcase
        end
    end

    assign bus.timerIrq    = pend && ie;
    assign bus.accessFault = fault;

    // RAM is never reset, but writes in a reset cycle are still dropped.
    always_ff @(posedge clk) begin
        if (reset && bus.memWr && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wrMask[i]) begin
                    ram[ram_idx][8*i +: 8] <= bus.memWriteData[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mtime    <= 64'd0;
            mtimecmp <= '1;
            en       <= 1'b0;
            ie       <= 1'b0;
            pend     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            fault <= unmapped && (bus.memWr || rd_en);

            // A write to either half freezes the whole counter for this edge.
            if (time_wr) begin
                if (off == OFF_MTIME_LO) begin
                    mtime[31:0] <= merge_lanes(mtime[31:0], bus.memWriteData, bus.wrMask);
                end else begin
                    mtime[63:32] <= merge_lanes(mtime[63:32], bus.memWriteData, bus.wrMask);
                end
            end else if (en) begin
                mtime <= mtime + 64'd1;
            end

            if (mmio_wr && off == OFF_CMP_LO) begin
                mtimecmp[31:0] <= merge_lanes(mtimecmp[31:0], bus.memWriteData, bus.wrMask);
            end
            if (mmio_wr && off == OFF_CMP_HI) begin
                mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], bus.memWriteData, bus.wrMask);
            end

            if (mmio_wr && off == OFF_CTRL && bus.wrMask[0]) begin
                en <= bus.memWriteData[0];
                ie <= bus.memWriteData[1];
            end

            // Set dominates clear when the compare is still true.
            pend <= (mtime >= mtimecmp) || (pend && !clr_write);
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, timer, interrupt, reset, faults.
module tb_dmem_responder;
    localparam logic [31:0] MB       = 32'hF000_0000;
    localparam logic [31:0] A_LO     = MB + 32'h00;
    localparam logic [31:0] A_HI     = MB + 32'h04;
    localparam logic [31:0] A_CMPLO  = MB + 32'h08;
    localparam logic [31:0] A_CMPHI  = MB + 32'h0C;
    localparam logic [31:0] A_CTRL   = MB + 32'h10;
    localparam logic [31:0] A_STATUS = MB + 32'h14;
    localparam logic [31:0] A_RSVD   = MB + 32'h18;
    localparam logic [31:0] A_BAD    = 32'h8000_0000;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    dmem_if bus ();

    dmem_responder #(.RAM_WORDS(1024), .MMIO_BASE(MB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic wr, input logic [3:0] m,
                         input logic [31:0] d);
        bus.memAddr      = a;
        bus.memWr        = wr;
        bus.wrMask       = m;
        bus.memWriteData = d;
        #1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        drive(a, 1'b0, 4'h0, 32'h0);
        check(tag, 64'(bus.memReadData), 64'(exp));
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        drive(a, 1'b1, m, d);
        cycle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        cycle();
        cycle();
        check("rst_irq", 64'(bus.timerIrq), 64'd0);
        check("rst_fault", 64'(bus.accessFault), 64'd0);
        rd("rst_mtime_lo", A_LO, 32'h0);
        rd("rst_cmp_lo", A_CMPLO, 32'hFFFF_FFFF);
        rd("rst_cmp_hi", A_CMPHI, 32'hFFFF_FFFF);
        reset = 1'b1;
        cycle();

        // RAM lanes and read-during-write
        wr(32'h10, 4'hF, 32'hDEAD_BEEF);
        drive(32'h10, 1'b1, 4'b0010, 32'h0000_AA00);
        check("ram_rdw_old", 64'(bus.memReadData), 64'h0000_0000_DEAD_BEEF);
        cycle();
        rd("ram_lane", 32'h10, 32'hDEAD_AAEF);

        // Counter enable, count, load and carry into HI
        wr(A_CTRL, 4'hF, 32'h1);
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        repeat (5) cycle();
        rd("cnt_5", A_LO, 32'd5);
        cycle();
        wr(A_LO, 4'hF, 32'hFFFF_FFFF);
        rd("cnt_load", A_LO, 32'hFFFF_FFFF);
        rd("cnt_load_hi", A_HI, 32'h0);
        cycle();
        rd("cnt_carry_hi", A_HI, 32'h1);
        rd("cnt_carry_lo", A_LO, 32'h0);

        // Interrupt on compare, W1C with set-wins, clear once compare is false
        wr(A_CTRL, 4'hF, 32'h0);
        wr(A_HI, 4'hF, 32'h0);
        wr(A_LO, 4'hF, 32'h0);
        wr(A_CMPHI, 4'hF, 32'h0);
        wr(A_CMPLO, 4'hF, 32'h3);
        wr(A_CTRL, 4'hF, 32'h3);
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        repeat (3) cycle();
        rd("irq_mtime3", A_LO, 32'd3);
        check("irq_not_yet", 64'(bus.timerIrq), 64'd0);
        cycle();
        check("irq_rise", 64'(bus.timerIrq), 64'd1);
        wr(A_STATUS, 4'h1, 32'h1);
        check("irq_set_wins", 64'(bus.timerIrq), 64'd1);
        rd("status_pend", A_STATUS, 32'h1);
        wr(A_CMPHI, 4'hF, 32'h1);
        wr(A_STATUS, 4'h1, 32'h1);
        check("irq_cleared", 64'(bus.timerIrq), 64'd0);
        rd("status_clr", A_STATUS, 32'h0);

        // Reset mid-operation with a RAM write presented
        wr(A_CMPHI, 4'hF, 32'h0);
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        cycle();
        check("pre_rst_irq", 64'(bus.timerIrq), 64'd1);
        reset = 1'b0;
        drive(32'h10, 1'b1, 4'hF, 32'h1234_5678);
        cycle();
        reset = 1'b1;
        rd("rst_ram_kept", 32'h10, 32'hDEAD_AAEF);
        check("rst_irq2", 64'(bus.timerIrq), 64'd0);
        rd("rst_mtime2", A_LO, 32'h0);
        rd("rst_cmp2", A_CMPHI, 32'hFFFF_FFFF);
        rd("rst_ctrl", A_CTRL, 32'h0);
        rd("rst_status", A_STATUS, 32'h0);

        // Unmapped read and write
        wr(32'h0, 4'hF, 32'h1122_3344);
        rd("unm_rd_data", A_BAD, 32'h0);
        check("unm_no_fault_yet", 64'(bus.accessFault), 64'd0);
        cycle();
        drive(32'h10, 1'b0, 4'h0, 32'h0);
        check("unm_fault", 64'(bus.accessFault), 64'd1);
        cycle();
        check("unm_fault_pulse", 64'(bus.accessFault), 64'd0);
        wr(A_BAD, 4'hF, 32'hFFFF_FFFF);
        check("unm_wr_fault", 64'(bus.accessFault), 64'd1);
        rd("unm_ram0", 32'h0, 32'h1122_3344);
        rd("unm_ctrl", A_CTRL, 32'h0);
        rd("unm_mtime", A_LO, 32'h0);

        // Reserved offset and partial CTRL
        wr(A_RSVD, 4'hF, 32'hFFFF_FFFF);
        check("rsvd_no_fault", 64'(bus.accessFault), 64'd0);
        rd("rsvd_read", A_RSVD, 32'h0);
        wr(A_CTRL, 4'hF, 32'hFFFF_FFFF);
        rd("ctrl_mask", A_CTRL, 32'h3);

        // 64-bit wrap; compare with all-ones cmp fires on the max value
        wr(A_HI, 4'hF, 32'hFFFF_FFFF);
        wr(A_LO, 4'hF, 32'hFFFF_FFFE);
        drive(32'h0, 1'b0, 4'h0, 32'h0);
        cycle();
        rd("wrap_max_lo", A_LO, 32'hFFFF_FFFF);
        check("wrap_max_irq", 64'(bus.timerIrq), 64'd0);
        cycle();
        rd("wrap_lo", A_LO, 32'h0);
        rd("wrap_hi", A_HI, 32'h0);
        check("wrap_irq", 64'(bus.timerIrq), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
